// File: rtl/ptos_pkg.sv
// Shared types and constants for the PTOS transmit scheduler.
// Symbol width, idle symbol and scheduler state encoding.
package ptos_pkg;

  localparam int SYM_BITS = 8;
  localparam logic [SYM_BITS-1:0] COM_SYMBOL = 8'hBC;

  typedef enum logic {
    TRAIN  = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ptos_tx_scheduler_if.sv
// Requester-side and serializer-side bundle of the scheduler.
// master: requester/serializer agent, slave: the scheduler.
interface ptos_tx_scheduler_if
  import ptos_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int IDW = cnt_w(NUM_REQ);

  logic [NUM_REQ-1:0]          req_valid;
  logic [SYM_BITS*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]          req_ready;
  logic [SYM_BITS-1:0]         ser_in;
  logic                        ser_in_valid;
  logic [IDW-1:0]              grant_id;
  logic                        byte_strobe;
  logic                        trained;

  modport master (
    output req_valid, req_data,
    input  req_ready, ser_in, ser_in_valid,
    input  grant_id, byte_strobe, trained
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, ser_in, ser_in_valid,
    output grant_id, byte_strobe, trained
  );

endinterface

// File: rtl/ptos_rr_arbiter.sv
// Rotating-priority pick: first valid request at or after ptr_i.
// The owner is masked out at its burst limit when others wait.
module ptos_rr_arbiter
  import ptos_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = cnt_w(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  input  logic [IDW-1:0] owner_i,
  input  logic           limit_i,
  output logic [IDW-1:0] win_o,
  output logic           found_o
);

  logic [N-1:0] own_oh;
  logic [N-1:0] others;
  logic [N-1:0] mask;

  always_comb begin
    own_oh  = N'(1) << owner_i;
    others  = req_i & ~own_oh;
    mask    = (limit_i && |others) ? others : req_i;
    win_o   = '0;
    found_o = 1'b0;
    // Walk downward so the lowest offset from ptr_i wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[(int'(ptr_i) + k) % N]) begin
        win_o   = IDW'((int'(ptr_i) + k) % N);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ptos_tx_scheduler.sv
// Round-robin byte scheduler feeding one parallel-to-serial unit.
// Trains with idle windows after reset, then grants per window.
module ptos_tx_scheduler
  import ptos_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int TRAIN_WINDOWS = 4,
  parameter int BURST_MAX     = 4
) (
  input logic                clk32f,
  input logic                reset,
  ptos_tx_scheduler_if.slave bus
);

  localparam int IDW = cnt_w(NUM_REQ);
  localparam int TCW = cnt_w(TRAIN_WINDOWS);
  localparam int BCW = cnt_w(BURST_MAX);
  localparam logic [TCW-1:0] T_LAST  = TCW'(TRAIN_WINDOWS - 1);
  localparam logic [BCW-1:0] B_LAST  = BCW'(BURST_MAX - 1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(NUM_REQ - 1);

  state_e              state_q;
  logic [2:0]          bit_cnt_q;
  logic [TCW-1:0]      train_cnt_q;
  logic [IDW-1:0]      rr_ptr_q;
  logic [BCW-1:0]      burst_cnt_q;
  logic [SYM_BITS-1:0] ser_in_q;
  logic                ser_vld_q;
  logic [IDW-1:0]      grant_q;
  logic                trained_q;

  logic                decide;
  logic                limit;
  logic                found;
  logic                same;
  logic [IDW-1:0]      win;
  logic [IDW-1:0]      ptr_d;
  logic [BCW-1:0]      burst_d;
  logic [SYM_BITS-1:0] sel_data;

  assign decide = (bit_cnt_q == 3'd7);
  assign limit  = ser_vld_q && (burst_cnt_q == B_LAST);

  ptos_rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .owner_i (grant_q),
    .limit_i (limit),
    .win_o   (win),
    .found_o (found)
  );

  always_comb begin
    same    = ser_vld_q && (win == grant_q);
    burst_d = '0;
    if (same)
      burst_d = (burst_cnt_q == B_LAST) ? B_LAST : burst_cnt_q + 1'b1;
    // A burst that just hit its limit hands priority to the next index.
    ptr_d = win;
    if (burst_d == B_LAST)
      ptr_d = (win == ID_LAST) ? '0 : win + 1'b1;
    sel_data = bus.req_data[SYM_BITS*int'(win) +: SYM_BITS];
    bus.req_ready = '0;
    if (decide && (state_q == ACTIVE) && found)
      bus.req_ready = NUM_REQ'(1) << win;
  end

  always_ff @(posedge clk32f) begin
    if (!reset) begin
      state_q     <= TRAIN;
      bit_cnt_q   <= '0;
      train_cnt_q <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      ser_in_q    <= '0;
      ser_vld_q   <= 1'b0;
      grant_q     <= '0;
      trained_q   <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
      if (decide) begin
        unique case (state_q)
          TRAIN: begin
            ser_in_q    <= '0;
            ser_vld_q   <= 1'b0;
            train_cnt_q <= train_cnt_q + 1'b1;
            if (train_cnt_q == T_LAST) begin
              state_q   <= ACTIVE;
              trained_q <= 1'b1;
            end
          end
          ACTIVE: begin
            if (found) begin
              ser_in_q    <= sel_data;
              ser_vld_q   <= 1'b1;
              grant_q     <= win;
              burst_cnt_q <= burst_d;
              rr_ptr_q    <= ptr_d;
            end else begin
              ser_in_q    <= '0;
              ser_vld_q   <= 1'b0;
              burst_cnt_q <= '0;
            end
          end
        endcase
      end
    end
  end

  assign bus.ser_in       = ser_in_q;
  assign bus.ser_in_valid = ser_vld_q;
  assign bus.grant_id     = grant_q;
  assign bus.byte_strobe  = decide;
  assign bus.trained      = trained_q;

endmodule

// File: tb/tb_ptos_tx_scheduler.sv
// Bench for ptos_tx_scheduler: directed scenarios, then random
// traffic, all against a window-level reference model.
module tb_ptos_tx_scheduler;
  import ptos_pkg::*;

  localparam int N  = 4;
  localparam int TW = 4;
  localparam int BM = 4;

  logic clk32f = 1'b0;
  logic reset  = 1'b0;
  always #5 clk32f = ~clk32f;

  ptos_tx_scheduler_if #(.NUM_REQ(N)) bus ();

  ptos_tx_scheduler #(
    .NUM_REQ       (N),
    .TRAIN_WINDOWS (TW),
    .BURST_MAX     (BM)
  ) dut (
    .clk32f (clk32f),
    .reset  (reset),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: window position, training progress, burst run.
  int   bc, twin, last, run, start, e_gid;
  bit   m_tr, pv, armed, e_vld, rnd_d, rnd_v;
  logic [7:0] e_ser;
  logic [7:0] bytes3 [3];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bc = 0; twin = 0; last = 0; run = 0; start = 0; e_gid = 0;
    m_tr = 0; pv = 0; e_vld = 0; e_ser = 8'h00;
  endtask

  // Called at the falling edge: check outputs, then predict the next edge.
  task automatic model_step();
    int w;
    bit f;
    int nr;
    logic [31:0] exp_rdy;
    f = 0;
    w = 0;
    if (bc == 7 && m_tr) begin
      for (int k = 0; k < N; k++) begin
        if (!f && bus.req_valid[(start + k) % N]) begin
          f = 1;
          w = (start + k) % N;
        end
      end
    end
    if (armed) begin
      exp_rdy = f ? (32'd1 << w) : 32'd0;
      chk("byte_strobe", 32'(bus.byte_strobe), 32'(bc == 7));
      chk("req_ready", 32'(bus.req_ready), exp_rdy);
      chk("ser_in_valid", 32'(bus.ser_in_valid), 32'(e_vld));
      chk("ser_in", 32'(bus.ser_in), 32'(e_ser));
      chk("grant_id", 32'(bus.grant_id), 32'(e_gid));
      chk("trained", 32'(bus.trained), 32'(m_tr));
    end
    if (!reset) begin
      model_reset();
      armed = 1;
    end else if (armed) begin
      if (bc == 7) begin
        if (!m_tr) begin
          twin++;
          e_vld = 0;
          e_ser = 8'h00;
          if (twin == TW) m_tr = 1;
        end else if (f) begin
          nr    = (pv && w == last) ? ((run + 1 > BM) ? BM : run + 1) : 1;
          run   = nr;
          start = (nr == BM) ? (w + 1) % N : w;
          last  = w;
          pv    = 1;
          e_ser = bus.req_data[8*w +: 8];
          e_vld = 1;
          e_gid = w;
        end else begin
          pv    = 0;
          run   = 0;
          e_vld = 0;
          e_ser = 8'h00;
        end
      end
      bc = (bc + 1) % 8;
    end
  endtask

  task automatic cyc();
    @(negedge clk32f);
    model_step();
    @(posedge clk32f);
    #1;
    if (rnd_d) bus.req_data = {$urandom, $urandom};
    if (rnd_v && $urandom_range(0, 7) == 0) bus.req_valid = N'($urandom);
  endtask

  task automatic to_bc(int k);
    int g;
    g = 0;
    while (bc != k && g < 16) begin
      cyc();
      g++;
    end
    chk("bc_reach", 32'(bc), 32'(k));
  endtask

  task automatic train_phase();
    bit rdy_seen;
    bit vld_seen;
    rdy_seen = 0;
    vld_seen = 0;
    reset = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    for (int c = 0; c < 8 * TW; c++) begin
      chk("trained_early", 32'(bus.trained), 32'd0);
      cyc();
      if (c < 8 * TW - 1) rdy_seen |= (bus.req_ready != '0);
      vld_seen |= bus.ser_in_valid;
    end
    chk("train_no_ready", 32'(rdy_seen), 32'd0);
    chk("train_no_valid", 32'(vld_seen), 32'd0);
    chk("trained_at_32", 32'(bus.trained), 32'd1);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    rnd_d = 0;
    rnd_v = 0;
    armed = 0;
    model_reset();
    @(posedge clk32f);
    #1;

    // Training then fairness: four bytes per requester in turn.
    bus.req_valid = '1;
    rnd_d = 1;
    train_phase();
    for (int win = 0; win < 16; win++) begin
      repeat (8) cyc();
      chk("fair_valid", 32'(bus.ser_in_valid), 32'd1);
      chk("fair_order", 32'(bus.grant_id), 32'(win / 4));
    end

    // Single requester with fixed bytes.
    rnd_d = 0;
    bus.req_valid = 4'b0100;
    bytes3[0] = 8'hA5;
    bytes3[1] = 8'h3C;
    bytes3[2] = 8'hF0;
    for (int b = 0; b < 3; b++) begin
      bus.req_data[23:16] = bytes3[b];
      to_bc(7);
      cyc();
      chk("single_data", 32'(bus.ser_in), 32'(bytes3[b]));
      chk("single_gid", 32'(bus.grant_id), 32'd2);
      chk("single_vld", 32'(bus.ser_in_valid), 32'd1);
    end

    // Alternating requesters 1 and 3, then nobody.
    for (int a = 0; a < 4; a++) begin
      bus.req_valid = (a % 2 == 0) ? 4'b0010 : 4'b1000;
      to_bc(7);
      cyc();
      chk("alt_gid", 32'(bus.grant_id), (a % 2 == 0) ? 32'd1 : 32'd3);
    end
    bus.req_valid = '0;
    to_bc(7);
    cyc();
    chk("idle_vld", 32'(bus.ser_in_valid), 32'd0);
    chk("idle_ser", 32'(bus.ser_in), 32'd0);

    // Request pulse that misses the decision cycle.
    to_bc(2);
    bus.req_valid = 4'b0010;
    repeat (4) cyc();
    bus.req_valid = '0;
    to_bc(7);
    chk("pulse_no_ready", 32'(bus.req_ready), 32'd0);
    cyc();
    chk("pulse_idle", 32'(bus.ser_in_valid), 32'd0);

    // Reset in the middle of a burst.
    bus.req_valid = 4'b0001;
    train_phase();
    repeat (8) cyc();
    to_bc(3);
    chk("burst_running", 32'(bus.ser_in_valid), 32'd1);
    reset = 1'b0;
    cyc();
    chk("rst_vld", 32'(bus.ser_in_valid), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_trained", 32'(bus.trained), 32'd0);
    train_phase();

    // Random traffic with occasional resets.
    rnd_d = 1;
    rnd_v = 1;
    for (int r = 0; r < 3000; r++) begin
      reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
